// File: rtl/qformat_mac.sv
// qformat_mac: signed Q-format multiply-accumulate with a saturating
// accumulator, round-half-up requantization and a one-deep result holding
// register with a valid/ready handshake on both sides.
//
// One dot product is accumulated in ACC. The beat flagged in_last moves the
// block to HOLD. The rounded and saturated result is captured on that same
// edge, so out_valid rises one clock after the last beat. The result stays
// in HOLD until it is handed off. The handoff clears the accumulator and the
// sticky overflow flag, ready for the next product.
module qformat_mac #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PROD_W = 2 * DATA_W;

    // Saturation bounds of the accumulator and of the output word.
    localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Half an output LSB. Adding it before the arithmetic shift rounds half up.
    localparam logic [ACC_W:0] ROUND_K =
        (FRAC_W > 0) ? (ACC_W+1)'(1) << (FRAC_W - 1) : '0;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ACC_W-1:0]  acc_reg;
    logic              sticky_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_sat_reg;

    logic              accept;
    logic              handoff;
    logic [PROD_W-1:0] product;
    logic [ACC_W:0]    sum_wide;
    logic              acc_ovf;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W:0]    rnd_sum;
    logic [ACC_W:0]    shifted;
    logic [ACC_W:DATA_W-1] shifted_hi;
    logic              q_ovf;
    logic [DATA_W-1:0] q_data;

    assign accept  = (state_reg == ST_ACC) && in_valid;
    assign handoff = (state_reg == ST_HOLD) && out_ready;

    // Datapath: product, saturating accumulate, round, shift and clamp.
    always_comb begin
        product  = PROD_W'($signed(a_data) * $signed(b_data));
        // One guard bit above the accumulator shows whether the add overflowed.
        sum_wide = {acc_reg[ACC_W-1], acc_reg}
                 + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
        acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (acc_ovf) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
        // The guard bit also keeps the rounding constant from wrapping ACC_MAX.
        rnd_sum    = {acc_next[ACC_W-1], acc_next} + ROUND_K;
        shifted    = $unsigned($signed(rnd_sum) >>> FRAC_W);
        shifted_hi = shifted[ACC_W:DATA_W-1];
        // The value fits the output word only if every bit from the output
        // sign bit upward is a copy of that sign bit.
        q_ovf      = !((&shifted_hi) || !(|shifted_hi));
        if (q_ovf) begin
            q_data = shifted[ACC_W] ? OUT_MIN : OUT_MAX;
        end else begin
            q_data = shifted[DATA_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: the last beat enters HOLD, and the handoff leaves it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC:  if (in_valid && in_last) state_next = ST_HOLD;
            ST_HOLD: if (out_ready)           state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    // Output logic: each handshake signal is decoded straight from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Accumulator and sticky overflow. Both are cleared only when the result is handed off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (handoff) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (accept) begin
            acc_reg    <= acc_next;
            sticky_reg <= sticky_reg | acc_ovf;
        end
    end

    // Result register. It loads on the last beat and then holds through HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else if (accept && in_last) begin
            out_data_reg <= q_data;
            out_sat_reg  <= sticky_reg | acc_ovf | q_ovf;
        end
    end

    assign out_data = out_data_reg;
    assign out_sat  = out_sat_reg;

endmodule

// File: tb/tb_qformat_mac.sv
// tb_qformat_mac: directed vectors with hand-computed results.
// Two instances share all inputs: one at the default 24-bit accumulator and
// one with a 16-bit accumulator, so that accumulator saturation and the
// sticky flag can be reached with 8-bit operands.
`timescale 1ns/1ps
module tb_qformat_mac;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_data = '0;
    logic [7:0] b_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready24, out_sat24, out_valid24;
    logic [7:0] out_data24;
    logic       in_ready16, out_sat16, out_valid16;
    logic [7:0] out_data16;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];

    always #5 clk = ~clk;

    qformat_mac dut24 (
        .clk(clk), .reset(reset), .a_data(a_data), .b_data(b_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready24),
        .out_data(out_data24), .out_sat(out_sat24), .out_valid(out_valid24),
        .out_ready(out_ready)
    );

    qformat_mac #(.DATA_W(8), .FRAC_W(7), .ACC_W(16)) dut16 (
        .clk(clk), .reset(reset), .a_data(a_data), .b_data(b_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready16),
        .out_data(out_data16), .out_sat(out_sat16), .out_valid(out_valid16),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand the result off and confirm both instances are back in ACC.
    task automatic do_handoff(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "/post_valid"}, {31'd0, out_valid24}, 32'd0);
        check({name, "/post_ready"}, {31'd0, in_ready24}, 32'd1);
        check({name, "/post_valid16"}, {31'd0, out_valid16}, 32'd0);
    endtask

    // Feed va/vb[0..n-1] with last on the final beat, check the result one
    // clock later on both instances, then hand it off.
    task automatic run_product(input string name, input int n,
                               input logic [7:0] e24, input logic s24,
                               input logic [7:0] e16, input logic s16);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_data   = va[i];
            b_data   = vb[i];
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            check({name, "/beat_ready"}, {31'd0, in_ready24}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({name, "/valid"},   {31'd0, out_valid24}, 32'd1);
        check({name, "/data"},    {24'd0, out_data24}, {24'd0, e24});
        check({name, "/sat"},     {31'd0, out_sat24}, {31'd0, s24});
        check({name, "/rdy_low"}, {31'd0, in_ready24}, 32'd0);
        check({name, "/valid16"}, {31'd0, out_valid16}, 32'd1);
        check({name, "/data16"},  {24'd0, out_data16}, {24'd0, e16});
        check({name, "/sat16"},   {31'd0, out_sat16}, {31'd0, s16});
        $display("txn %s: out24=0x%02h sat24=%0d out16=0x%02h sat16=%0d",
                 name, out_data24, out_sat24, out_data16, out_sat16);
        do_handoff(name);
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst/valid", {31'd0, out_valid24}, 32'd0);
        check("rst/data",  {24'd0, out_data24}, 32'd0);
        check("rst/sat",   {31'd0, out_sat24}, 32'd0);
        check("rst/ready", {31'd0, in_ready24}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        $display("txn reset released");

        // 0.5 * 0.5 = 0.25
        va[0] = 8'h40; vb[0] = 8'h40;
        run_product("half_sq", 1, 8'h20, 1'b0, 8'h20, 1'b0);

        // A product of 64 is exactly half an LSB, so it rounds up to 1.
        va[0] = 8'h01; vb[0] = 8'h40;
        run_product("round_up", 1, 8'h01, 1'b0, 8'h01, 1'b0);
        // A product of 63 is below half an LSB, so it rounds down to 0.
        va[0] = 8'h01; vb[0] = 8'h3F;
        run_product("round_dn", 1, 8'h00, 1'b0, 8'h00, 1'b0);

        // -1 * 127/128 = -16256, and (-16256+64)>>>7 = -127.
        va[0] = 8'h80; vb[0] = 8'h7F;
        run_product("negative", 1, 8'h81, 1'b0, 8'h81, 1'b0);

        // 3*16129 overflows the output word. The 16-bit accumulator also clamps.
        va[0] = 8'h7F; vb[0] = 8'h7F;
        va[1] = 8'h7F; vb[1] = 8'h7F;
        va[2] = 8'h7F; vb[2] = 8'h7F;
        run_product("out_clamp", 3, 8'h7F, 1'b1, 8'h7F, 1'b1);
        va[0] = 8'h40; vb[0] = 8'h40;
        run_product("after_clamp", 1, 8'h20, 1'b0, 8'h20, 1'b0);

        // The 16-bit accumulator clamps at 32767 and is then pulled back down.
        // 24-bit: 48387-32512=15875 gives 124, with no saturation.
        // 16-bit: 32767-32512=255 gives 2, with the sticky flag set.
        va[0] = 8'h7F; vb[0] = 8'h7F;
        va[1] = 8'h7F; vb[1] = 8'h7F;
        va[2] = 8'h7F; vb[2] = 8'h7F;
        va[3] = 8'h80; vb[3] = 8'h7F;
        va[4] = 8'h80; vb[4] = 8'h7F;
        run_product("sticky", 5, 8'h7C, 1'b0, 8'h02, 1'b1);
        va[0] = 8'h40; vb[0] = 8'h40;
        run_product("sticky_clr", 1, 8'h20, 1'b0, 8'h20, 1'b0);

        // in_last without in_valid must neither end the product nor add a beat.
        @(negedge clk);
        a_data = 8'h40; b_data = 8'h40; in_valid = 1'b1; in_last = 1'b0;
        @(negedge clk);
        a_data = 8'h7F; b_data = 8'h7F; in_valid = 1'b0; in_last = 1'b1;
        @(negedge clk);
        check("lastnv/no_valid", {31'd0, out_valid24}, 32'd0);
        a_data = 8'h40; b_data = 8'h40; in_valid = 1'b1; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("lastnv/valid", {31'd0, out_valid24}, 32'd1);
        check("lastnv/data",  {24'd0, out_data24}, 32'h40);
        $display("txn lastnv: out24=0x%02h sat24=%0d", out_data24, out_sat24);
        do_handoff("lastnv");

        // Backpressure: the result stays put while pairs are offered and ignored.
        @(negedge clk);
        a_data = 8'h80; b_data = 8'h7F; in_valid = 1'b1; in_last = 1'b1;
        @(negedge clk);
        a_data = 8'h7F; b_data = 8'h7F; in_valid = 1'b1; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp/valid", {31'd0, out_valid24}, 32'd1);
            check("bp/data",  {24'd0, out_data24}, 32'h81);
            check("bp/sat",   {31'd0, out_sat24}, 32'd0);
            check("bp/ready", {31'd0, in_ready24}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        $display("txn backpressure: out24=0x%02h held 5 cycles", out_data24);
        do_handoff("bp");
        // The next product must start from an empty accumulator, so no ignored pair was added.
        va[0] = 8'h40; vb[0] = 8'h40;
        run_product("after_bp", 1, 8'h20, 1'b0, 8'h20, 1'b0);

        // Reset in the middle of a four-beat product discards the partial sum.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_data = 8'h40; b_data = 8'h40; in_valid = 1'b1; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst/valid", {31'd0, out_valid24}, 32'd0);
        check("midrst/ready", {31'd0, in_ready24}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        check("midrst/no_stale", {31'd0, out_valid24}, 32'd0);
        $display("txn mid-product reset");
        va[0] = 8'h40; vb[0] = 8'h40;
        run_product("after_rst", 1, 8'h20, 1'b0, 8'h20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
